// File: rtl/mips_alu_pkg.sv
// Shared decode constants, ALU control codes and muldiv FSM states for the EX-stage ALU control.
package mips_alu_pkg;

  // R-type funct codes
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;

  // I-type opcodes
  localparam logic [5:0] OPC_SLTI = 6'b001010;
  localparam logic [5:0] OPC_ANDI = 6'b001100;
  localparam logic [5:0] OPC_ORI  = 6'b001101;
  localparam logic [5:0] OPC_XORI = 6'b001110;

  // ALUOp from main control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  // ALU control codes
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SLL     = 4'b0011;
  localparam logic [3:0] ALU_SRL     = 4'b0100;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_NOR     = 4'b1100;
  localparam logic [3:0] ALU_XOR     = 4'b1101;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1110;
  localparam logic [3:0] ALU_IDLE    = 4'b1111;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StFix  = 2'b10
  } md_state_e;

  // Funct codes that touch HI/LO and therefore must wait for the engine
  function automatic logic is_hilo_funct(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) || (f == FUNCT_DIV) || (f == FUNCT_DIVU) ||
           (f == FUNCT_MFHI) || (f == FUNCT_MFLO) || (f == FUNCT_MTHI) || (f == FUNCT_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_engine.sv
// Iterative one-bit-per-cycle multiply/divide engine owning the HI/LO registers.
module muldiv_engine
  import mips_alu_pkg::*;
#(
  parameter int unsigned NB_DATA = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               is_div_i,
  input  logic               is_signed_i,
  input  logic [NB_DATA-1:0] rs_i,
  input  logic [NB_DATA-1:0] rt_i,
  input  logic               wr_hi_i,
  input  logic               wr_lo_i,
  output logic               busy_o,
  output logic               div_by_zero_o,
  output logic [NB_DATA-1:0] hi_o,
  output logic [NB_DATA-1:0] lo_o
);

  localparam int unsigned NB_CNT = $clog2(NB_DATA) + 1;

  md_state_e            state_q;
  logic [NB_CNT-1:0]    cnt_q;
  logic                 is_div_q;
  logic                 neg_q;     // product / quotient sign
  logic                 rneg_q;    // remainder sign (dividend sign)
  logic                 b_zero_q;
  logic                 dbz_q;
  logic [NB_DATA-1:0]   mag_b_q;   // |rt|: multiplicand or divisor
  logic [NB_DATA-1:0]   acc_hi_q;  // upper product / partial remainder
  logic [NB_DATA-1:0]   acc_lo_q;  // multiplier bits / dividend bits -> quotient
  logic [NB_DATA-1:0]   hi_q;
  logic [NB_DATA-1:0]   lo_q;

  logic                 rs_neg, rt_neg;
  logic [NB_DATA-1:0]   rs_mag, rt_mag;
  logic [NB_DATA:0]     mul_sum, rem_sh, rem_diff;
  logic [NB_DATA-1:0]   step_hi, step_lo;
  logic [2*NB_DATA-1:0] prod_fix;
  logic [NB_DATA-1:0]   quot_fix, rem_fix;

  // Operand magnitudes, one iteration step and the final sign correction
  always_comb begin
    rs_neg   = is_signed_i & rs_i[NB_DATA-1];
    rt_neg   = is_signed_i & rt_i[NB_DATA-1];
    rs_mag   = rs_neg ? (~rs_i + 1'b1) : rs_i;
    rt_mag   = rt_neg ? (~rt_i + 1'b1) : rt_i;
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : '0);
    rem_sh   = {acc_hi_q, acc_lo_q[NB_DATA-1]};
    rem_diff = rem_sh - {1'b0, mag_b_q};
    if (is_div_q) begin
      // Borrow out of the N+1-bit subtract means the divisor did not fit
      step_hi = rem_diff[NB_DATA] ? rem_sh[NB_DATA-1:0] : rem_diff[NB_DATA-1:0];
      step_lo = {acc_lo_q[NB_DATA-2:0], ~rem_diff[NB_DATA]};
    end else begin
      step_hi = mul_sum[NB_DATA:1];
      step_lo = {mul_sum[0], acc_lo_q[NB_DATA-1:1]};
    end
    prod_fix = neg_q ? (~{acc_hi_q, acc_lo_q} + 1'b1) : {acc_hi_q, acc_lo_q};
    quot_fix = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
    rem_fix  = rneg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
  end

  // FSM, iteration datapath and HI/LO state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      b_zero_q <= 1'b0;
      dbz_q    <= 1'b0;
      mag_b_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      dbz_q <= 1'b0;
      if (wr_hi_i) hi_q <= rs_i;
      if (wr_lo_i) lo_q <= rs_i;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            is_div_q <= is_div_i;
            neg_q    <= rs_neg ^ rt_neg;
            rneg_q   <= rs_neg;
            b_zero_q <= (rt_i == '0);
            mag_b_q  <= rt_mag;
            acc_hi_q <= '0;
            acc_lo_q <= rs_mag;
            cnt_q    <= '0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == NB_CNT'(NB_DATA - 1)) begin
            state_q <= StFix;
            dbz_q   <= is_div_q & b_zero_q;
          end
        end
        StFix: begin
          if (is_div_q) begin
            // With a zero divisor every bit of |rs| shifts into the remainder, so the
            // sign-corrected remainder is rs itself; only LO needs forcing.
            lo_q <= b_zero_q ? '1 : quot_fix;
            hi_q <= rem_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o        = (state_q != StIdle);
  assign div_by_zero_o = dbz_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: rtl/alu_control_muldiv.sv
// EX-stage ALU control decode with HI/LO access, muldiv engine and stall handshake.
module alu_control_muldiv
  import mips_alu_pkg::*;
#(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_FUNCT    = 6,
  parameter int unsigned NB_ALUOP_IN = 2,
  parameter int unsigned NB_ALUCTRL  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_Valid,
  input  logic [NB_FUNCT-1:0]    i_Funct,
  input  logic [NB_FUNCT-1:0]    i_Opcode,
  input  logic [NB_ALUOP_IN-1:0] i_ALUOp,
  input  logic [NB_DATA-1:0]     i_RsData,
  input  logic [NB_DATA-1:0]     i_RtData,
  output logic [NB_ALUCTRL-1:0]  o_ALUCtrl,
  output logic                   o_Illegal,
  output logic                   o_SelHiLo,
  output logic [NB_DATA-1:0]     o_HiLoData,
  output logic                   o_Stall,
  output logic                   o_Busy,
  output logic                   o_DivByZero
);

  logic               is_rtype, hilo_op, md_op, mfhi_op, mflo_op;
  logic               md_start, wr_hi, wr_lo;
  logic               busy;
  logic [NB_DATA-1:0] hi, lo;

  // ALU control decode; anything unrecognised maps to the illegal code
  always_comb begin
    o_ALUCtrl = ALU_ILLEGAL;
    o_Illegal = 1'b1;
    unique case (i_ALUOp)
      ALUOP_ADD: begin o_ALUCtrl = ALU_ADD; o_Illegal = 1'b0; end
      ALUOP_SUB: begin o_ALUCtrl = ALU_SUB; o_Illegal = 1'b0; end
      ALUOP_RTYPE: begin
        o_Illegal = 1'b0;
        case (i_Funct)
          FUNCT_ADD, FUNCT_ADDU: o_ALUCtrl = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: o_ALUCtrl = ALU_SUB;
          FUNCT_AND:             o_ALUCtrl = ALU_AND;
          FUNCT_OR:              o_ALUCtrl = ALU_OR;
          FUNCT_NOR:             o_ALUCtrl = ALU_NOR;
          FUNCT_XOR:             o_ALUCtrl = ALU_XOR;
          FUNCT_SLT:             o_ALUCtrl = ALU_SLT;
          FUNCT_SLL:             o_ALUCtrl = ALU_SLL;
          FUNCT_SRL:             o_ALUCtrl = ALU_SRL;
          FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
          FUNCT_MFHI, FUNCT_MFLO, FUNCT_MTHI, FUNCT_MTLO: o_ALUCtrl = ALU_IDLE;
          default: begin o_ALUCtrl = ALU_ILLEGAL; o_Illegal = 1'b1; end
        endcase
      end
      ALUOP_ITYPE: begin
        o_Illegal = 1'b0;
        case (i_Opcode)
          OPC_SLTI: o_ALUCtrl = ALU_SLT;
          OPC_ANDI: o_ALUCtrl = ALU_AND;
          OPC_ORI:  o_ALUCtrl = ALU_OR;
          OPC_XORI: o_ALUCtrl = ALU_XOR;
          default: begin o_ALUCtrl = ALU_ILLEGAL; o_Illegal = 1'b1; end
        endcase
      end
      default: ;
    endcase
  end

  // HI/LO op classification, stall handshake and MFxx result mux
  always_comb begin
    is_rtype   = (i_ALUOp == ALUOP_RTYPE);
    hilo_op    = is_rtype & is_hilo_funct(i_Funct);
    md_op      = is_rtype & ((i_Funct == FUNCT_MULT) | (i_Funct == FUNCT_MULTU) |
                             (i_Funct == FUNCT_DIV)  | (i_Funct == FUNCT_DIVU));
    mfhi_op    = is_rtype & (i_Funct == FUNCT_MFHI);
    mflo_op    = is_rtype & (i_Funct == FUNCT_MFLO);
    o_Stall    = busy & i_Valid & hilo_op;
    md_start   = i_Valid & md_op & ~o_Stall;
    wr_hi      = i_Valid & is_rtype & (i_Funct == FUNCT_MTHI) & ~o_Stall;
    wr_lo      = i_Valid & is_rtype & (i_Funct == FUNCT_MTLO) & ~o_Stall;
    o_SelHiLo  = i_Valid & (mfhi_op | mflo_op);
    o_HiLoData = '0;
    if (i_Valid & mfhi_op) o_HiLoData = hi;
    if (i_Valid & mflo_op) o_HiLoData = lo;
  end

  assign o_Busy = busy;

  muldiv_engine #(
    .NB_DATA (NB_DATA)
  ) u_muldiv_engine (
    .clk_i         (i_clk),
    .rst_i         (i_reset),
    .start_i       (md_start),
    .is_div_i      (i_Funct[1]),
    .is_signed_i   (~i_Funct[0]),
    .rs_i          (i_RsData),
    .rt_i          (i_RtData),
    .wr_hi_i       (wr_hi),
    .wr_lo_i       (wr_lo),
    .busy_o        (busy),
    .div_by_zero_o (o_DivByZero),
    .hi_o          (hi),
    .lo_o          (lo)
  );

endmodule
